// File: rtl/i2c_read_sched_if.sv
// Bundle of request, result and engine-side signals for the shared
// I2C register-read scheduler. The scheduler uses the master modport.
// The clients and the read engine use the slave modport.
interface i2c_read_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] dev_addr;
    logic [8*NREQ-1:0] reg_addr;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rd_valid;
    logic [7:0]        rd_data;
    logic              rd_err;
    logic              busy;
    logic              eng_ena;
    logic [6:0]        eng_dev_addr;
    logic [7:0]        eng_reg_addr;
    logic [7:0]        eng_data;
    logic              eng_done;

    modport master (
        input  req, dev_addr, reg_addr, eng_data, eng_done,
        output gnt, rd_valid, rd_data, rd_err, busy,
               eng_ena, eng_dev_addr, eng_reg_addr
    );

    modport slave (
        output req, dev_addr, reg_addr, eng_data, eng_done,
        input  gnt, rd_valid, rd_data, rd_err, busy,
               eng_ena, eng_dev_addr, eng_reg_addr
    );
endinterface

// File: rtl/i2c_read_sched.sv
// Round-robin scheduler that shares one I2C register-read engine among
// NREQ requesters. It launches one read at a time and waits for the engine
// to finish or for the timeout to expire. It then returns the byte to the
// winner and holds the engine disabled for a short gap.
module i2c_read_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4095,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    i2c_read_sched_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;

    state_t          stateReg, stateNext;
    logic [15:0]     cntReg, cntNext;
    logic [15:0]     gapReg, gapNext;
    logic [PW-1:0]   ptrReg, ptrNext;
    logic [PW-1:0]   gIdxReg, gIdxNext;
    logic [NREQ-1:0] gntReg, gntNext;
    logic [NREQ-1:0] rdValidReg, rdValidNext;
    logic [7:0]      rdDataReg, rdDataNext;
    logic            rdErrReg, rdErrNext;
    logic            busyReg;
    logic            engEnaReg, engEnaNext;
    logic [6:0]      engDevReg, engDevNext;
    logic [7:0]      engRegReg, engRegNext;

    logic [6:0]      devSlice [NREQ];
    logic [7:0]      regSlice [NREQ];
    logic            pickValid;
    logic [PW-1:0]   pickIdx;

    // Split the flat address buses into per-requester slices.
    for (genvar gi = 0; gi < NREQ; gi++) begin : gSlice
        assign devSlice[gi] = bus.dev_addr[7*gi +: 7];
        assign regSlice[gi] = bus.reg_addr[8*gi +: 8];
    end

    // Find the first active request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] cand;
        pickValid = 1'b0;
        pickIdx   = '0;
        sum       = '0;
        cand      = '0;
        for (int off = 0; off < NREQ; off++) begin
            sum = {1'b0, ptrReg} + (PW+1)'(off);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            cand = sum[PW-1:0];
            if (!pickValid && bus.req[cand]) begin
                pickValid = 1'b1;
                pickIdx   = cand;
            end
        end
    end

    // Next-state and next-output logic for the launch/run/done/gap sequence.
    always_comb begin
        stateNext   = stateReg;
        cntNext     = cntReg;
        gapNext     = gapReg;
        ptrNext     = ptrReg;
        gIdxNext    = gIdxReg;
        gntNext     = gntReg;
        rdValidNext = '0;
        rdDataNext  = rdDataReg;
        rdErrNext   = rdErrReg;
        engEnaNext  = engEnaReg;
        engDevNext  = engDevReg;
        engRegNext  = engRegReg;
        case (stateReg)
            IDLE: begin
                if (pickValid) begin
                    gIdxNext   = pickIdx;
                    gntNext    = NREQ'(1) << pickIdx;
                    engDevNext = devSlice[pickIdx];
                    engRegNext = regSlice[pickIdx];
                    engEnaNext = 1'b1;
                    cntNext    = '0;
                    stateNext  = RUN;
                end
            end
            RUN: begin
                cntNext = cntReg + 16'd1;
                // A completion in the same cycle as the timeout wins.
                if (bus.eng_done) begin
                    rdDataNext  = bus.eng_data;
                    rdErrNext   = 1'b0;
                    rdValidNext = gntReg;
                    stateNext   = DONE;
                end else if (cntReg == 16'(TIMEOUT - 1)) begin
                    rdDataNext  = 8'hFF;
                    rdErrNext   = 1'b1;
                    rdValidNext = gntReg;
                    stateNext   = DONE;
                end
            end
            DONE: begin
                engEnaNext = 1'b0;
                gntNext    = '0;
                ptrNext    = (gIdxReg == PW'(NREQ - 1)) ? '0 : gIdxReg + PW'(1);
                // The DONE->GAP edge is the first low cycle and IDLE is the last one.
                // GAP therefore only covers the remaining GAP_CYC-2 cycles.
                gapNext    = (GAP_CYC > 1) ? 16'(GAP_CYC - 2) : 16'd0;
                stateNext  = (GAP_CYC > 1) ? GAP : IDLE;
            end
            GAP: begin
                if (gapReg == 16'd0) begin
                    stateNext = IDLE;
                end else begin
                    gapNext = gapReg - 16'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= IDLE;
            cntReg     <= '0;
            gapReg     <= '0;
            ptrReg     <= '0;
            gIdxReg    <= '0;
            gntReg     <= '0;
            rdValidReg <= '0;
            rdDataReg  <= '0;
            rdErrReg   <= 1'b0;
            busyReg    <= 1'b0;
            engEnaReg  <= 1'b0;
            engDevReg  <= '0;
            engRegReg  <= '0;
        end else begin
            stateReg   <= stateNext;
            cntReg     <= cntNext;
            gapReg     <= gapNext;
            ptrReg     <= ptrNext;
            gIdxReg    <= gIdxNext;
            gntReg     <= gntNext;
            rdValidReg <= rdValidNext;
            rdDataReg  <= rdDataNext;
            rdErrReg   <= rdErrNext;
            busyReg    <= (stateNext != IDLE);
            engEnaReg  <= engEnaNext;
            engDevReg  <= engDevNext;
            engRegReg  <= engRegNext;
        end
    end

    assign bus.gnt          = gntReg;
    assign bus.rd_valid     = rdValidReg;
    assign bus.rd_data      = rdDataReg;
    assign bus.rd_err       = rdErrReg;
    assign bus.busy         = busyReg;
    assign bus.eng_ena      = engEnaReg;
    assign bus.eng_dev_addr = engDevReg;
    assign bus.eng_reg_addr = engRegReg;
endmodule

// File: tb/tb_i2c_read_sched.sv
// Testbench for i2c_read_sched with two instances.
// Instance 0 uses TIMEOUT=4095 and instance 1 uses TIMEOUT=100.
// Each instance has an engine model that returns reg_addr^AA after a set delay.
// A monitor pops the expected grants and completions from queues and compares them.
`timescale 1ns/1ps
module tb_i2c_read_sched;
    localparam int NREQ    = 4;
    localparam int GAP_CYC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [NREQ-1:0]   reqV [2];
    logic [7*NREQ-1:0] devV [2];
    logic [8*NREQ-1:0] regV [2];
    int                doneDelay [2];
    logic [NREQ-1:0]   rdvW [2];

    typedef struct {
        int         inst;
        int         idx;
        logic [6:0] dev;
        logic [7:0] rg;
    } gntExp_t;

    typedef struct {
        int         inst;
        int         idx;
        logic [7:0] data;
        logic       err;
        int         lat;
    } rdExp_t;

    gntExp_t gntQ[$];
    rdExp_t  rdQ[$];

    i2c_read_sched_if #(.NREQ(NREQ)) bus [2] ();

    for (genvar gi = 0; gi < 2; gi++) begin : gInst
        localparam int TMO = (gi == 0) ? 4095 : 100;
        logic            engDone   = 1'b0;
        logic [7:0]      engData   = 8'h00;
        int              engCnt    = 0;
        int              cyc       = 0;
        int              launchCyc = 0;
        int              lowCnt    = 0;
        int              lat       = 0;
        logic            prevEna   = 1'b0;
        logic [NREQ-1:0] expOh;
        gntExp_t         ge;
        rdExp_t          re;

        assign bus[gi].req      = reqV[gi];
        assign bus[gi].dev_addr = devV[gi];
        assign bus[gi].reg_addr = regV[gi];
        assign bus[gi].eng_done = engDone;
        assign bus[gi].eng_data = engData;
        assign rdvW[gi]         = bus[gi].rd_valid;

        i2c_read_sched #(.NREQ(NREQ), .TIMEOUT(TMO), .GAP_CYC(GAP_CYC)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus[gi])
        );

        // Engine model: done goes high doneDelay cycles after enable rises and clears when enable is low.
        always @(negedge clk) begin
            if (!bus[gi].eng_ena) begin
                engCnt  = 0;
                engDone = 1'b0;
            end else begin
                engCnt++;
                if (doneDelay[gi] != 0 && engCnt == doneDelay[gi]) engDone = 1'b1;
            end
            engData = bus[gi].eng_reg_addr ^ 8'hAA;
        end

        // Monitor: check each launch against the grant queue and each rd_valid against the result queue.
        always @(posedge clk) begin
            #1;
            cyc++;
            if (rst) begin
                prevEna = 1'b0;
                lowCnt  = GAP_CYC;
            end else begin
                if (bus[gi].eng_ena && !prevEna) begin
                    vectors++;
                    if (lowCnt < GAP_CYC) begin
                        miscompares++;
                        $display("FAIL gap inst%0d: enable low %0d cycles, need >= %0d", gi, lowCnt, GAP_CYC);
                    end
                    launchCyc = cyc;
                    vectors++;
                    if (gntQ.size() == 0) begin
                        miscompares++;
                        $display("FAIL grant inst%0d: unexpected gnt=%b", gi, bus[gi].gnt);
                    end else begin
                        ge    = gntQ.pop_front();
                        expOh = NREQ'(1) << ge.idx;
                        if (ge.inst != gi || bus[gi].gnt !== expOh ||
                            bus[gi].eng_dev_addr !== ge.dev || bus[gi].eng_reg_addr !== ge.rg) begin
                            miscompares++;
                            $display("FAIL grant inst%0d: got gnt=%b dev=%h reg=%h, want inst%0d gnt=%b dev=%h reg=%h",
                                     gi, bus[gi].gnt, bus[gi].eng_dev_addr, bus[gi].eng_reg_addr,
                                     ge.inst, expOh, ge.dev, ge.rg);
                        end else begin
                            $display("inst%0d grant gnt=%b dev=%h reg=%h", gi, bus[gi].gnt,
                                     bus[gi].eng_dev_addr, bus[gi].eng_reg_addr);
                        end
                    end
                end
                if (bus[gi].eng_ena) lowCnt = 0;
                else lowCnt++;
                prevEna = bus[gi].eng_ena;

                if (bus[gi].rd_valid != '0) begin
                    vectors++;
                    lat = cyc - launchCyc;
                    if (rdQ.size() == 0) begin
                        miscompares++;
                        $display("FAIL result inst%0d: unexpected rd_valid=%b", gi, bus[gi].rd_valid);
                    end else begin
                        re    = rdQ.pop_front();
                        expOh = NREQ'(1) << re.idx;
                        if (re.inst != gi || bus[gi].rd_valid !== expOh || bus[gi].rd_data !== re.data ||
                            bus[gi].rd_err !== re.err || (re.lat >= 0 && lat != re.lat)) begin
                            miscompares++;
                            $display("FAIL result inst%0d: got rd_valid=%b data=%h err=%b lat=%0d, want inst%0d rd_valid=%b data=%h err=%b lat=%0d",
                                     gi, bus[gi].rd_valid, bus[gi].rd_data, bus[gi].rd_err, lat,
                                     re.inst, expOh, re.data, re.err, re.lat);
                        end else begin
                            $display("inst%0d result rd_valid=%b data=%h err=%b lat=%0d", gi,
                                     bus[gi].rd_valid, bus[gi].rd_data, bus[gi].rd_err, lat);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    task automatic waitRd(input int inst, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rdvW[inst] == '0 && n < budget);
        if (rdvW[inst] == '0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_rd inst%0d: no rd_valid within %0d cycles", inst, budget);
        end
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pushG(input int inst, input int idx, input logic [6:0] dev, input logic [7:0] rg);
        gntExp_t e;
        e.inst = inst; e.idx = idx; e.dev = dev; e.rg = rg;
        gntQ.push_back(e);
    endtask

    task automatic pushR(input int inst, input int idx, input logic [7:0] data, input logic err, input int lat);
        rdExp_t e;
        e.inst = inst; e.idx = idx; e.data = data; e.err = err; e.lat = lat;
        rdQ.push_back(e);
    endtask

    // Round-robin table for instance 0: requester i uses dev 10+i and reg 20+i.
    // Expected data is (20+i)^AA, written out by hand.
    logic [7:0] rrData [4] = '{8'h8A, 8'h8B, 8'h88, 8'h89};

    // Directed stimulus sequence.
    initial begin
        for (int i = 0; i < 2; i++) begin
            reqV[i] = '0; devV[i] = '0; regV[i] = '0; doneDelay[i] = 0;
        end
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_gnt",      32'(bus[0].gnt), 32'h0);
        check("rst_rd_valid", 32'(bus[0].rd_valid), 32'h0);
        check("rst_rd_data",  32'(bus[0].rd_data), 32'h0);
        check("rst_rd_err",   32'(bus[0].rd_err), 32'h0);
        check("rst_busy",     32'(bus[0].busy), 32'h0);
        check("rst_eng_ena",  32'(bus[0].eng_ena), 32'h0);
        check("rst_eng_dev",  32'(bus[0].eng_dev_addr), 32'h0);
        check("rst_eng_reg",  32'(bus[0].eng_reg_addr), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single request: requester 1, dev 48, reg 0F, engine answers after 900 cycles.
        devV[0][7 +: 7] = 7'h48;
        regV[0][8 +: 8] = 8'h0F;
        doneDelay[0] = 900;
        pushG(0, 1, 7'h48, 8'h0F);
        pushR(0, 1, 8'hA5, 1'b0, 900);
        reqV[0] = 4'b0010;
        @(negedge clk);
        check("single_gnt",  32'(bus[0].gnt), 32'h2);
        check("single_dev",  32'(bus[0].eng_dev_addr), 32'h48);
        check("single_reg",  32'(bus[0].eng_reg_addr), 32'h0F);
        check("single_ena",  32'(bus[0].eng_ena), 32'h1);
        check("single_busy", 32'(bus[0].busy), 32'h1);
        waitRd(0, 1000);
        check("single_rdv",  32'(bus[0].rd_valid), 32'h2);
        check("single_data", 32'(bus[0].rd_data), 32'hA5);
        check("single_err",  32'(bus[0].rd_err), 32'h0);
        reqV[0] = '0;
        @(negedge clk);
        check("done_rdv_pulse", 32'(bus[0].rd_valid), 32'h0);
        check("done_ena_low",   32'(bus[0].eng_ena), 32'h0);
        check("done_gnt_low",   32'(bus[0].gnt), 32'h0);
        check("gap_busy",       32'(bus[0].busy), 32'h1);
        check("data_held",      32'(bus[0].rd_data), 32'hA5);
        @(negedge clk);
        check("gap_ena_low2",   32'(bus[0].eng_ena), 32'h0);
        check("idle_busy",      32'(bus[0].busy), 32'h0);

        // Round robin from ptr=0 with all four requesting: order 0,1,2,3,0.
        pulseReset();
        devV[0] = {7'h13, 7'h12, 7'h11, 7'h10};
        regV[0] = {8'h23, 8'h22, 8'h21, 8'h20};
        doneDelay[0] = 5;
        for (int k = 0; k < 5; k++) begin
            pushG(0, k % 4, 7'(8'h10 + 8'(k % 4)), 8'h20 + 8'(k % 4));
            pushR(0, k % 4, rrData[k % 4], 1'b0, 5);
        end
        reqV[0] = 4'b1111;
        for (int k = 0; k < 5; k++) waitRd(0, 100);
        reqV[0] = '0;
        repeat (5) @(negedge clk);

        // Reset mid-RUN: ptr is 1, so 1001 first grants 3. After reset, ptr=0 grants 0.
        pushG(0, 3, 7'h13, 8'h23);
        pushG(0, 0, 7'h10, 8'h20);
        pushR(0, 0, 8'h8A, 1'b0, 200);
        doneDelay[0] = 200;
        reqV[0] = 4'b1001;
        @(negedge clk);
        check("prereset_gnt", 32'(bus[0].gnt), 32'h8);
        repeat (49) @(negedge clk);
        pulseReset();
        check("midrst_gnt",      32'(bus[0].gnt), 32'h0);
        check("midrst_rd_valid", 32'(bus[0].rd_valid), 32'h0);
        check("midrst_rd_data",  32'(bus[0].rd_data), 32'h0);
        check("midrst_rd_err",   32'(bus[0].rd_err), 32'h0);
        check("midrst_busy",     32'(bus[0].busy), 32'h0);
        check("midrst_eng_ena",  32'(bus[0].eng_ena), 32'h0);
        check("midrst_eng_dev",  32'(bus[0].eng_dev_addr), 32'h0);
        check("midrst_eng_reg",  32'(bus[0].eng_reg_addr), 32'h0);
        @(negedge clk);
        check("relaunch_gnt", 32'(bus[0].gnt), 32'h1);
        waitRd(0, 300);
        reqV[0] = '0;
        repeat (4) @(negedge clk);

        // Withdrawn request: ptr=1, requester 2 drops req mid-RUN and changes its addresses.
        pushG(0, 2, 7'h12, 8'h22);
        pushR(0, 2, 8'h88, 1'b0, 30);
        doneDelay[0] = 30;
        reqV[0] = 4'b0100;
        @(negedge clk);
        check("withdraw_gnt", 32'(bus[0].gnt), 32'h4);
        repeat (10) @(negedge clk);
        reqV[0] = '0;
        devV[0][14 +: 7] = 7'h7F;
        regV[0][16 +: 8] = 8'hEE;
        @(negedge clk);
        check("withdraw_dev_kept", 32'(bus[0].eng_dev_addr), 32'h12);
        check("withdraw_reg_kept", 32'(bus[0].eng_reg_addr), 32'h22);
        check("withdraw_gnt_kept", 32'(bus[0].gnt), 32'h4);
        waitRd(0, 100);
        // ptr must now be 3: with requesters 0 and 3 active, 3 goes first.
        pushG(0, 3, 7'h13, 8'h23);
        pushR(0, 3, 8'h89, 1'b0, 30);
        reqV[0] = 4'b1001;
        waitRd(0, 100);
        reqV[0] = '0;
        repeat (4) @(negedge clk);

        // Instance 1 (TIMEOUT=100): requester 0 times out, then requester 1 collides done with timeout.
        devV[1][0 +: 7] = 7'h2A;
        devV[1][7 +: 7] = 7'h2B;
        regV[1][0 +: 8] = 8'h40;
        regV[1][8 +: 8] = 8'h41;
        doneDelay[1] = 0;
        pushG(1, 0, 7'h2A, 8'h40);
        pushR(1, 0, 8'hFF, 1'b1, 100);
        pushG(1, 1, 7'h2B, 8'h41);
        pushR(1, 1, 8'hEB, 1'b0, 100);
        reqV[1] = 4'b0011;
        waitRd(1, 200);
        check("timeout_data", 32'(bus[1].rd_data), 32'hFF);
        check("timeout_err",  32'(bus[1].rd_err), 32'h1);
        doneDelay[1] = 100;
        reqV[1] = 4'b0010;
        waitRd(1, 200);
        check("collide_data", 32'(bus[1].rd_data), 32'hEB);
        check("collide_err",  32'(bus[1].rd_err), 32'h0);
        reqV[1] = '0;
        repeat (4) @(negedge clk);

        check("gnt_queue_empty", 32'(gntQ.size()), 32'h0);
        check("rd_queue_empty",  32'(rdQ.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
